uart_tx_mmio: RTL
=================

# uart_tx_mmio

Memory-mapped UART transmitter on the single-cycle MIPS core's data-memory port. It consumes the core's store traffic (`memwrite`, `aluout` as address, `writedata`) and drives a `readdata` contribution for loads from its address window. Stored bytes are buffered in a small FIFO and serialised as 8N1 frames on `tx`. The top level muxes `readdata` from this block or data memory using `sel`.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: 16-byte aligned base of the register window.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, default 4: TX FIFO entries; must be a power of 2, ≥2.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `memwrite`  in  1: store strobe from the core.
- `addr`  in  32: byte address (core `aluout`).
- `writedata`  in  32: store data.
- `readdata`  out  32: combinational read value; 0 when `sel`=0.
- `sel`  out  1: combinational; 1 when `addr[31:4]` == `BASE_ADDR[31:4]`.
- `tx`  out  1: registered serial output; idles at 1.
- `busy`  out  1: registered; 1 while a frame is being shifted out.

## Operation
- Decode: word offset `addr[3:2]`; `addr[1:0]` ignored. Writes act only when `sel` and `memwrite` are both 1.
- Offset 0, TXDATA:
  - Write pushes `writedata[7:0]` into the FIFO.
  - Read returns 0.
- Offset 1, STATUS (read):
  - bit0 full.
  - bit1 empty.
  - bit2 busy.
  - bit3 overflow (sticky).
  - bits[11:8] FIFO count, zero-extended or truncated to 4 bits.
  - All other bits 0.
  - Any write to STATUS clears overflow.
- Offsets 2, 3: reserved. Reads return 0; writes are ignored.
- FIFO push rules:
  - A push when full is dropped and sets overflow.
  - Exception: if a pop occurs in the same cycle, the push is accepted and count is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1, `busy`=0. If the FIFO is non-empty, pop the head into an 8-bit shift register and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: drive `shift[0]`, LSB first. Each bit is held `CLKS_PER_BIT` cycles, then shift right. After 8 bits go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- `busy`=1 in START, DATA and STOP.
- Bit timer: counts 0..`CLKS_PER_BIT`-1 and reloads 0 on each bit boundary. Bit index is 3 bits, 0..7.
- Reset outputs and state: state IDLE, `tx`=1, `busy`=0, FIFO empty (pointers and count 0), overflow=0, timer 0.
- Reset mid-frame aborts the frame: `tx`=1 after the reset edge and the FIFO is flushed. A push in the same cycle as `reset` is discarded.

## Timing
- `readdata` and `sel` are purely combinational, so a core load completes in its single cycle.
- Push at edge N: the FIFO is non-empty after N. The IDLE pop occurs at edge N+1, so `tx` falls and `busy` rises after edge N+1.
- One frame = 10·`CLKS_PER_BIT` cycles from the `tx` falling edge to the end of STOP.
- Back-to-back queued bytes: frames are contiguous. Next start bit begins the cycle after the stop bit's last cycle.
- STATUS reflects register state before the current edge; a same-cycle push is not visible.

## Test plan
Use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4 for all scenarios.
- Reset: assert `reset` 2 cycles → `tx`=1, `busy`=0, STATUS read at BASE+4 = 32'h0000_0002.
- Single byte: store 32'h1234_56A5 to BASE+0 → `tx` low at the edge after the push for 4 cycles. Then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop 1 for 4 cycles. `busy` high for 40 cycles, then STATUS = 0x0002.
- Fill/overflow: 6 consecutive stores of 0x01..0x06 while idle. The first byte is popped one cycle after its push, so 0x01..0x05 are accepted and 0x06 is dropped. STATUS then shows full=1, overflow=1, count=4. Serial output is 0x01..0x05 with no gaps between frames. A write to BASE+4 clears overflow.
- Simultaneous push/pop at full: align a store with the STOP-end pop while count=4 → push accepted, count stays 4, no overflow.
- Decode: store to BASE+8, BASE+12 and BASE_ADDR+16 → no FIFO change; `sel`=0 at BASE_ADDR+16; reads of BASE+0 and BASE+8 return 0.
- Reset mid-frame: `reset` during the DATA bit 3 → the next cycle `tx`=1, `busy`=0, count=0; no further frame is sent.

Source files
------------

// File: rtl/uart_tx_mmio_if.sv
// Data-memory port bundle between the MIPS core and the memory-mapped UART.
// The core drives the store strobe, address and store data. The peripheral
// returns its read contribution and the window-select flag.
interface uart_tx_mmio_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sel;

  modport master (
    output memwrite,
    output addr,
    output writedata,
    input  readdata,
    input  sel
  );

  modport slave (
    input  memwrite,
    input  addr,
    input  writedata,
    output readdata,
    output sel
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter. Stored bytes are queued in a small FIFO
// and shifted out LSB first on tx. A STATUS register exposes the FIFO and
// line state to polling code on the core.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_nxt;
  logic [TW-1:0]  timer, timer_nxt;
  logic [2:0]     bitidx, bitidx_nxt;
  logic [7:0]     shift, shift_nxt;
  logic           tx_d, busy_d;
  logic           pop;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;
  logic           ovf;

  logic [1:0]     off;
  logic           wr, push, push_ok, clr_ovf, full, empty, bit_end;
  logic [7:0]     head;
  logic [31:0]    cnt_ext;
  logic [31:0]    status;
  logic           unused_ok;

  // Register window decode; addr[1:0] is a byte offset within the word and is ignored.
  assign off      = bus.addr[3:2];
  assign bus.sel  = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign wr       = bus.sel & bus.memwrite;
  assign push     = wr && (off == 2'd0);
  assign clr_ovf  = wr && (off == 2'd1);

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // A push at full still lands when the transmitter frees a slot in the same cycle.
  assign push_ok  = push && (!full || pop);
  assign head     = mem[rptr];
  assign bit_end  = (timer == TW'(CLKS_PER_BIT - 1));

  // Count field is a fixed 4-bit slot regardless of FIFO depth.
  assign cnt_ext  = 32'(count);
  assign status   = {20'd0, cnt_ext[3:0], 4'd0, ovf, busy, empty, full};
  assign bus.readdata = (bus.sel && (off == 2'd1)) ? status : 32'd0;

  assign unused_ok = ^{bus.writedata[31:8], bus.addr[1:0], cnt_ext[31:4]};

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wptr] <= bus.writedata[7:0];
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      if (clr_ovf)              ovf <= 1'b0;
      else if (push && !push_ok) ovf <= 1'b1;
    end
  end

  // Transmit FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bit timer and bit index are control and return to zero on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer  <= '0;
      bitidx <= '0;
    end else begin
      timer  <= timer_nxt;
      bitidx <= bitidx_nxt;
    end
  end

  // Shift register holds frame data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

  // Registered line outputs so tx is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx   <= 1'b1;
      busy <= 1'b0;
    end else begin
      tx   <= tx_d;
      busy <= busy_d;
    end
  end

  // Next-state logic: frame sequencing, FIFO pops and bit timing.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = bit_end ? '0 : timer + 1'b1;
    bitidx_nxt = bitidx;
    shift_nxt  = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = head;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          bitidx_nxt = '0;
          state_nxt  = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = {1'b0, shift[7:1]};
          if (bitidx == 3'd7) state_nxt = STOP;
          else                bitidx_nxt = bitidx + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // Queued bytes chain straight into the next start bit.
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = head;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so tx/busy register in step with it.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_nxt)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = shift_nxt[0];
      default: ;
    endcase
  end

endmodule
